mshr_refill_ctrl: RTL and testbench
===================================

Name: mshr_refill_ctrl

Overview:
Miss-handling sequencer between the 4-way cache and the single memory port. It accepts one line miss at a time from the cache. If the victim is dirty, it first writes the victim line back word by word. It then refills the missing line critical-word-first with wrap-around, writing each word into the cache as it arrives, and signals when the critical word and the whole line are available.

Parameters:
ADR_WIDTH, 32, byte address width
DATA_WIDTH, 32, word width
WORD_OFFSET, 2, word-index bits; line = 2**WORD_OFFSET words (4)
BYTE_OFFSET, 2, byte-in-word bits; always 0 on the memory address

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
miss_req_i  in  1  cache requests miss service; sampled only in IDLE
miss_adr_i  in  ADR_WIDTH  missing address; word bits select the critical word
miss_dirty_i  in  1  victim line dirty, writeback required
victim_adr_i  in  ADR_WIDTH  victim line address; word/byte bits ignored
victim_word_o  out  WORD_OFFSET  word index the cache must drive on victim_dat_i
victim_dat_i  in  DATA_WIDTH  victim word, combinational from the cache
fill_we_o  out  1  write fill_dat_o into the cache at fill_word_o
fill_word_o  out  WORD_OFFSET  refill word index
fill_dat_o  out  DATA_WIDTH  refill data
crit_o  out  1  one-cycle pulse: critical word written, cache may ack the CPU
miss_busy_o  out  1  controller not in IDLE
miss_done_o  out  1  one-cycle pulse: full line installed
mem_req_o  out  1  memory request
mem_we_o  out  1  1 = write (writeback), 0 = read (refill)
mem_adr_o  out  ADR_WIDTH  {line address, word index, BYTE_OFFSET zeros}
mem_dat_o  out  DATA_WIDTH  writeback data
mem_ack_i  in  1  memory beat accepted/completed
mem_dat_i  in  DATA_WIDTH  read data, valid in the mem_ack_i cycle

Behaviour:
- Reset: state IDLE; beat counter 0; all outputs 0. Reset is asynchronous and effective mid-operation.
- On reset mid-refill, the partially filled line is not marked; the cache must invalidate its pending way on rst.
- FSM states: IDLE, WB, FILL, DONE.
- IDLE:
  - If miss_req_i, latch the line address, critical word (miss_adr_i word bits), dirty flag and victim line address.
  - Next state is WB if dirty, else FILL.
  - miss_req_i is ignored in all other states; the cache holds it until miss_done_o.
- WB:
  - mem_req_o=1, mem_we_o=1.
  - mem_adr_o = victim line + beat counter (words 0..3 in order).
  - victim_word_o = counter; mem_dat_o = victim_dat_i.
  - Each mem_ack_i cycle advances the counter. Address and data stay stable while ack is low.
  - After the ack of word 3: counter cleared, go to FILL.
- FILL:
  - mem_req_o=1, mem_we_o=0.
  - Word index = (crit + counter) mod 4, wrapping: crit=2 gives order 2,3,0,1.
  - In an ack cycle: fill_we_o=1, fill_word_o=index, fill_dat_o=mem_dat_i (combinational from the ack).
  - crit_o=1 on the first fill ack only.
  - After the 4th ack, go to DONE.
- DONE: miss_done_o=1 for one cycle, then IDLE. miss_busy_o=0 in DONE's following cycle, so a new miss is accepted at the earliest 2 cycles after the last ack.
- mem_req_o stays high continuously across beats within a phase; it drops only in IDLE and DONE.
- mem_ack_i outside WB/FILL is ignored.
- Ack every cycle gives: clean miss, done 5 cycles after acceptance; dirty miss, 9 cycles.
- miss_busy_o = (state != IDLE), registered.
- Word counter is WORD_OFFSET bits and wraps naturally. Phase end is detected at counter == all-ones with ack.

Decomposition:
- Shared package: ADR_WIDTH, DATA_WIDTH and WORD_OFFSET constants (shared with the cache and testbench), the state enum, and a LINE_WORDS = 1<<WORD_OFFSET constant.
- One natural sub-module, line_beat_counter: counter with clear, ack-advance, base offset add (wrap) and last-beat flag. It is instantiated once and reused for both phases.

Test Plan:
- Clean miss, adr 0x00CC3B43 (crit word 0), ack every cycle -> 4 reads at 0x00CC3B40/44/48/4C; crit_o with word 0; miss_done_o 5 cycles after acceptance; no mem_we_o.
- Clean miss, adr 0x00CC3B48 (crit 2) -> read order words 2,3,0,1; fill_word_o 2,3,0,1; crit_o on first beat only.
- Dirty miss, victim 0x00843B40 with data A0..A3, ack every 2nd cycle -> writes A0..A3 at 0x00843B40..4C with stable adr/dat while waiting, then 4 reads; done after 17 cycles.
- miss_req_i pulsed again while busy with a different address -> ignored; addresses unchanged; exactly one miss_done_o.
- rst asserted after 2nd fill beat -> all outputs 0 immediately without a clock; IDLE; new miss after reset restarts at crit word.
- Back-to-back misses (miss_req_i held, new address after done) -> second accepted in the cycle after DONE; no overlap of mem_req_o phases.

Source files
------------

// File: rtl/mshr_refill_ctrl_pkg.sv
// Shared constants, state encoding and address helper for the miss-handling sequencer.
// Imported by the cache, the controller and the testbench so line geometry stays in one place.
package mshr_refill_ctrl_pkg;

    localparam int ADR_WIDTH      = 32;
    localparam int DATA_WIDTH     = 32;
    localparam int WORD_OFFSET    = 2;
    localparam int BYTE_OFFSET    = 2;
    localparam int LINE_WORDS     = 1 << WORD_OFFSET;
    localparam int LINE_ADR_WIDTH = ADR_WIDTH - WORD_OFFSET - BYTE_OFFSET;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        FILL,
        DONE
    } mshrState_e;

    function automatic logic [ADR_WIDTH-1:0] wordAdr(
        input logic [LINE_ADR_WIDTH-1:0] line,
        input logic [WORD_OFFSET-1:0]    word
    );
        return {line, word, {BYTE_OFFSET{1'b0}}};
    endfunction

endpackage

// File: rtl/mshr_refill_ctrl_if.sv
// Single-port memory bus between the refill controller (master) and memory (slave).
// mem_ack qualifies one beat; mem_rdat is valid only in the ack cycle of a read.
interface mshr_refill_ctrl_if;
    import mshr_refill_ctrl_pkg::*;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADR_WIDTH-1:0]  mem_adr;
    logic [DATA_WIDTH-1:0] mem_wdat;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdat;

    modport master (
        output mem_req, mem_we, mem_adr, mem_wdat,
        input  mem_ack, mem_rdat
    );

    modport slave (
        input  mem_req, mem_we, mem_adr, mem_wdat,
        output mem_ack, mem_rdat
    );

endinterface

// File: rtl/mshr_refill_ctrl_line_beat_counter.sv
// Beat counter shared by the writeback and refill phases: counts acked beats and
// rotates the word index by a base offset so the refill starts at the critical word.
module line_beat_counter
    import mshr_refill_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_i,
    input  logic                   advance_i,
    input  logic [WORD_OFFSET-1:0] base_i,
    output logic [WORD_OFFSET-1:0] count_o,
    output logic [WORD_OFFSET-1:0] index_o,
    output logic                   last_o
);

    logic [WORD_OFFSET-1:0] count_q;
    logic [WORD_OFFSET-1:0] count_d;

    // The counter wraps to zero after the last beat, so a phase change needs no explicit clear.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (advance_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign index_o = base_i + count_q;
    assign last_o  = advance_i && (count_q == WORD_OFFSET'(LINE_WORDS - 1));

endmodule

// File: rtl/mshr_refill_ctrl.sv
// Miss sequencer: optional dirty-victim writeback, then critical-word-first refill
// of the missing line, with a pulse for the critical word and one for line completion.
module mshr_refill_ctrl
    import mshr_refill_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   miss_req_i,
    input  logic [ADR_WIDTH-1:0]   miss_adr_i,
    input  logic                   miss_dirty_i,
    input  logic [ADR_WIDTH-1:0]   victim_adr_i,
    output logic [WORD_OFFSET-1:0] victim_word_o,
    input  logic [DATA_WIDTH-1:0]  victim_dat_i,
    output logic                   fill_we_o,
    output logic [WORD_OFFSET-1:0] fill_word_o,
    output logic [DATA_WIDTH-1:0]  fill_dat_o,
    output logic                   crit_o,
    output logic                   miss_busy_o,
    output logic                   miss_done_o,
    mshr_refill_ctrl_if.master     mem
);

    mshrState_e                state_q;
    mshrState_e                state_d;
    logic [LINE_ADR_WIDTH-1:0] lineAdr_q;
    logic [LINE_ADR_WIDTH-1:0] victimLine_q;
    logic [WORD_OFFSET-1:0]    critWord_q;

    logic                      accept;
    logic                      beatAck;
    logic [WORD_OFFSET-1:0]    beatCount;
    logic [WORD_OFFSET-1:0]    beatIndex;
    logic                      lastBeat;
    logic                      unusedAdrBits;

    assign accept        = (state_q == IDLE) && miss_req_i;
    assign beatAck       = mem.mem_ack && ((state_q == WB) || (state_q == FILL));
    assign miss_busy_o   = (state_q != IDLE);
    assign unusedAdrBits = ^{miss_adr_i[BYTE_OFFSET-1:0],
                             victim_adr_i[WORD_OFFSET+BYTE_OFFSET-1:0]};

    line_beat_counter u_beatCounter (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (state_q == IDLE),
        .advance_i (beatAck),
        .base_i    ((state_q == FILL) ? critWord_q : '0),
        .count_o   (beatCount),
        .index_o   (beatIndex),
        .last_o    (lastBeat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            lineAdr_q    <= '0;
            victimLine_q <= '0;
            critWord_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                lineAdr_q    <= miss_adr_i[ADR_WIDTH-1 -: LINE_ADR_WIDTH];
                victimLine_q <= victim_adr_i[ADR_WIDTH-1 -: LINE_ADR_WIDTH];
                critWord_q   <= miss_adr_i[BYTE_OFFSET +: WORD_OFFSET];
            end
        end
    end

    // Fill data passes straight through from the memory ack so the cache writes it that cycle.
    always_comb begin
        state_d       = state_q;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_adr   = '0;
        mem.mem_wdat  = '0;
        victim_word_o = '0;
        fill_we_o     = 1'b0;
        fill_word_o   = '0;
        fill_dat_o    = '0;
        crit_o        = 1'b0;
        miss_done_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss_req_i) begin
                    state_d = miss_dirty_i ? WB : FILL;
                end
            end
            WB: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_adr   = wordAdr(victimLine_q, beatCount);
                mem.mem_wdat  = victim_dat_i;
                victim_word_o = beatCount;
                if (lastBeat) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                mem.mem_req = 1'b1;
                mem.mem_adr = wordAdr(lineAdr_q, beatIndex);
                if (mem.mem_ack) begin
                    fill_we_o   = 1'b1;
                    fill_word_o = beatIndex;
                    fill_dat_o  = mem.mem_rdat;
                    crit_o      = (beatCount == '0);
                end
                if (lastBeat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                miss_done_o = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mshr_refill_ctrl.sv
// Self-checking bench for mshr_refill_ctrl: a transaction-level model predicts every
// memory beat, cache write and pulse from the latched miss parameters.
module tb_mshr_refill_ctrl;
    import mshr_refill_ctrl_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   missReq;
    logic [ADR_WIDTH-1:0]   missAdr;
    logic                   missDirty;
    logic [ADR_WIDTH-1:0]   victimAdr;
    logic [WORD_OFFSET-1:0] victimWord;
    logic [DATA_WIDTH-1:0]  victimDat;
    logic                   fillWe;
    logic [WORD_OFFSET-1:0] fillWord;
    logic [DATA_WIDTH-1:0]  fillDat;
    logic                   crit;
    logic                   busy;
    logic                   done;
    logic [DATA_WIDTH-1:0]  victimMem [LINE_WORDS];

    int checks   = 0;
    int failures = 0;

    mshr_refill_ctrl_if memIf ();

    mshr_refill_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .miss_req_i    (missReq),
        .miss_adr_i    (missAdr),
        .miss_dirty_i  (missDirty),
        .victim_adr_i  (victimAdr),
        .victim_word_o (victimWord),
        .victim_dat_i  (victimDat),
        .fill_we_o     (fillWe),
        .fill_word_o   (fillWord),
        .fill_dat_o    (fillDat),
        .crit_o        (crit),
        .miss_busy_o   (busy),
        .miss_done_o   (done),
        .mem           (memIf.master)
    );

    always #5 clk = ~clk;

    // The cache answers the victim word index combinationally from its line buffer.
    assign victimDat = victimMem[victimWord];

    // Presents one miss, then plays memory for every beat and checks it against the model.
    task automatic serviceMiss(input logic [ADR_WIDTH-1:0] adr, input logic dirty,
                               input logic [ADR_WIDTH-1:0] vic, input int ackGap,
                               input bit churn, input bit holdReq, output int doneCycle);
        int wbBeats = dirty ? LINE_WORDS : 0;
        int beats   = wbBeats + LINE_WORDS;
        int b       = 0;
        int idle    = 0;
        int cyc     = 0;
        int word;
        bit ackNow;
        bit sawDone = 1'b0;
        logic [ADR_WIDTH-1:0]  expAdr;
        logic [DATA_WIDTH-1:0] rdat;
        doneCycle = -1;
        @(negedge clk);
        missReq = 1'b1; missAdr = adr; missDirty = dirty; victimAdr = vic;
        memIf.mem_ack = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("[TB] FAIL accept_idle: busy=%b expected 0", busy);
        end
        @(posedge clk);
        while (!sawDone && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (churn) begin
                missReq = 1'($urandom_range(0, 1)); missAdr = $urandom;
                missDirty = 1'($urandom_range(0, 1)); victimAdr = $urandom;
            end
            if (b < beats) begin
                ackNow = (ackGap == 0) ? ($urandom_range(0, 1) == 1) : (idle == ackGap - 1);
                rdat   = $urandom;
                memIf.mem_ack = ackNow; memIf.mem_rdat = rdat;
                #1;
                if (b < wbBeats) begin
                    word   = b;
                    expAdr = (vic & ~32'hF) + word * 4;
                end else begin
                    word   = (int'(adr[3:2]) + b - wbBeats) % LINE_WORDS;
                    expAdr = (adr & ~32'hF) + word * 4;
                end
                checks++;
                if ({memIf.mem_req, busy, done} !== 3'b110) begin
                    failures++; $display("[TB] FAIL beat_ctrl b=%0d: req/busy/done=%b expected 110", b, {memIf.mem_req, busy, done});
                end
                checks++;
                if (memIf.mem_we !== (b < wbBeats)) begin
                    failures++; $display("[TB] FAIL mem_we b=%0d: got %b expected %b", b, memIf.mem_we, b < wbBeats);
                end
                checks++;
                if (memIf.mem_adr !== expAdr) begin
                    failures++; $display("[TB] FAIL mem_adr b=%0d: got %h expected %h", b, memIf.mem_adr, expAdr);
                end
                if (b < wbBeats) begin
                    checks++;
                    if (victimWord !== word[1:0] || memIf.mem_wdat !== victimMem[word] || fillWe !== 1'b0) begin
                        failures++; $display("[TB] FAIL wb_data b=%0d: word=%0d dat=%h fillWe=%b expected word=%0d dat=%h fillWe=0",
                                             b, victimWord, memIf.mem_wdat, fillWe, word, victimMem[word]);
                    end
                end else begin
                    checks++;
                    if (fillWe !== ackNow) begin
                        failures++; $display("[TB] FAIL fill_we b=%0d: got %b expected %b", b, fillWe, ackNow);
                    end
                    if (ackNow) begin
                        checks++;
                        if (fillWord !== word[1:0] || fillDat !== rdat) begin
                            failures++; $display("[TB] FAIL fill_data b=%0d: word=%0d dat=%h expected word=%0d dat=%h",
                                                 b, fillWord, fillDat, word, rdat);
                        end
                    end
                end
                checks++;
                if (crit !== (ackNow && b == wbBeats)) begin
                    failures++; $display("[TB] FAIL crit b=%0d: got %b expected %b", b, crit, ackNow && b == wbBeats);
                end
                if (ackNow) begin
                    b++; idle = 0;
                end else begin
                    idle++;
                end
            end else begin
                memIf.mem_ack = 1'($urandom_range(0, 1));
                #1;
                checks++;
                if ({done, busy, memIf.mem_req, fillWe, crit} !== 5'b11000) begin
                    failures++; $display("[TB] FAIL done_cycle: done/busy/req/we/crit=%b expected 11000",
                                         {done, busy, memIf.mem_req, fillWe, crit});
                end
                sawDone   = 1'b1;
                doneCycle = cyc;
                missReq   = holdReq;
            end
        end
        memIf.mem_ack = 1'b0;
        if (!sawDone) begin
            checks++; failures++;
            $display("[TB] FAIL timeout: no miss_done after %0d cycles, expected within 200", cyc);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({memIf.mem_req, memIf.mem_we, memIf.mem_adr, memIf.mem_wdat, victimWord, fillWe, fillWord, fillDat, crit, busy, done} !== '0) begin
            failures++; $display("[TB] FAIL reset_outputs: req=%b busy=%b adr=%h expected all zero", memIf.mem_req, busy, memIf.mem_adr);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            memIf.mem_ack = 1'b1;
            #1;
            checks++;
            if ({busy, memIf.mem_req, fillWe} !== 3'b000) begin
                failures++; $display("[TB] FAIL idle_ack_ignored: busy/req/we=%b expected 000", {busy, memIf.mem_req, fillWe});
            end
        end
        memIf.mem_ack = 1'b0;
    endtask

    task automatic test_clean_crit0();
        int d;
        serviceMiss(32'h00CC3B43, 1'b0, 32'h0, 1, 1'b0, 1'b0, d);
        checks++;
        if (d !== 5) begin
            failures++; $display("[TB] FAIL clean_latency: got %0d expected 5", d);
        end
    endtask

    task automatic test_clean_wrap();
        int d;
        serviceMiss(32'h00CC3B48, 1'b0, 32'h0, 1, 1'b0, 1'b0, d);
        checks++;
        if (d !== 5) begin
            failures++; $display("[TB] FAIL wrap_latency: got %0d expected 5", d);
        end
    endtask

    task automatic test_dirty_slow();
        int d;
        for (int i = 0; i < LINE_WORDS; i++) victimMem[i] = 32'hA0 + i;
        serviceMiss(32'h00CC3B44, 1'b1, 32'h00843B40, 2, 1'b0, 1'b0, d);
        checks++;
        if (d !== 17) begin
            failures++; $display("[TB] FAIL dirty_latency: got %0d expected 17", d);
        end
    endtask

    task automatic test_ignore_while_busy();
        int d;
        serviceMiss(32'h1234_5678, 1'b1, 32'h0BAD_F00C, 1, 1'b1, 1'b0, d);
        checks++;
        if (d !== 9) begin
            failures++; $display("[TB] FAIL busy_latency: got %0d expected 9", d);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({done, busy, memIf.mem_req} !== 3'b000) begin
                failures++; $display("[TB] FAIL single_done: done/busy/req=%b expected 000", {done, busy, memIf.mem_req});
            end
        end
    endtask

    task automatic test_reset_midfill();
        int d;
        @(negedge clk);
        missReq = 1'b1; missAdr = 32'h00CC3B44; missDirty = 1'b0; victimAdr = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            memIf.mem_ack = 1'b1; memIf.mem_rdat = $urandom;
        end
        @(posedge clk);
        #2;
        checks++;
        if (memIf.mem_req !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("[TB] FAIL pre_reset: req=%b busy=%b expected 1 1", memIf.mem_req, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({memIf.mem_req, memIf.mem_we, memIf.mem_adr, memIf.mem_wdat, victimWord, fillWe, fillWord, fillDat, crit, busy, done} !== '0) begin
            failures++; $display("[TB] FAIL async_reset: req=%b we=%b busy=%b adr=%h expected all zero",
                                 memIf.mem_req, fillWe, busy, memIf.mem_adr);
        end
        @(negedge clk);
        memIf.mem_ack = 1'b0; missReq = 1'b0; rst = 1'b0;
        serviceMiss(32'h00CC3B44, 1'b0, 32'h0, 1, 1'b0, 1'b0, d);
        checks++;
        if (d !== 5) begin
            failures++; $display("[TB] FAIL restart_latency: got %0d expected 5", d);
        end
    endtask

    task automatic test_back_to_back();
        int d1;
        int d2;
        for (int i = 0; i < LINE_WORDS; i++) victimMem[i] = $urandom;
        serviceMiss(32'h0040_0008, 1'b0, 32'h0, 1, 1'b0, 1'b1, d1);
        serviceMiss(32'h0080_0014, 1'b1, 32'h00C0_0000, 1, 1'b0, 1'b0, d2);
        checks++;
        if (d1 !== 5 || d2 !== 9) begin
            failures++; $display("[TB] FAIL back_to_back_latency: got %0d/%0d expected 5/9", d1, d2);
        end
    endtask

    task automatic test_random();
        int d;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < LINE_WORDS; i++) victimMem[i] = $urandom;
            serviceMiss($urandom, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d);
        end
    endtask

    initial begin
        missReq = 1'b0; missAdr = '0; missDirty = 1'b0; victimAdr = '0;
        memIf.mem_ack = 1'b0; memIf.mem_rdat = '0;
        for (int i = 0; i < LINE_WORDS; i++) victimMem[i] = '0;
        $display("[TB] starting mshr_refill_ctrl bench");
        test_reset();
        test_clean_crit0();
        test_clean_wrap();
        test_dirty_slow();
        test_ignore_while_busy();
        test_reset_midfill();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
